// File: rtl/uart_pkt_tx.sv
// Framed 8N1 UART transmitter: header, 8 data bytes (MSB byte first),
// XOR checksum. One packet per rising edge of i_send_en.
module uart_pkt_tx #(
  parameter int          CLK_FREQ = 100_000_000,
  parameter int          UART_BPS = 115200,
  parameter logic [7:0]  HEADER   = 8'hA5
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_send_en,
  input  logic [63:0] i_send_data,
  output logic        o_tx_busy,
  output logic        o_send_done,
  output logic        o_uart_txd
);

  localparam int BAUD_CNT = CLK_FREQ / UART_BPS;
  localparam int BW = (BAUD_CNT > 1) ? $clog2(BAUD_CNT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_CNT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t      r_state;
  logic [BW-1:0] r_baud;
  logic [2:0]  r_bit;
  logic [3:0]  r_byte;
  logic        r_en_d;
  logic [7:0]  r_buf [10];
  logic        r_txd;
  logic        r_busy;
  logic        r_done;

  logic        w_accept;
  logic        w_baud_end;
  logic        w_txd_nxt;
  logic [7:0]  w_cur_byte;
  logic [7:0]  w_csum;

  assign w_accept   = i_send_en & ~r_en_d & (r_state == S_IDLE);
  assign w_baud_end = (r_baud == BAUD_LAST);
  assign w_cur_byte = r_buf[r_byte];

  always_comb begin
    w_csum = '0;
    for (int i = 0; i < 8; i++)
      w_csum = w_csum ^ i_send_data[i*8 +: 8];
  end

  always_comb begin
    w_txd_nxt = 1'b1;
    unique case (r_state)
      S_IDLE:  w_txd_nxt = 1'b1;
      S_START: w_txd_nxt = 1'b0;
      S_DATA:  w_txd_nxt = w_cur_byte[r_bit];
      S_STOP:  w_txd_nxt = 1'b1;
      default: w_txd_nxt = 1'b1;
    endcase
  end

  // Outputs are registered from the state, so the line lags the FSM by one
  // cycle; done fires on the first idle cycle after a busy one.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_byte  <= '0;
      r_en_d  <= 1'b1;
      r_txd   <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      for (int i = 0; i < 10; i++)
        r_buf[i] <= '0;
    end else begin
      r_en_d <= i_send_en;
      r_txd  <= w_txd_nxt;
      r_busy <= (r_state != S_IDLE);
      r_done <= r_busy & (r_state == S_IDLE);
      unique case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_state  <= S_START;
            r_byte   <= '0;
            r_bit    <= '0;
            r_baud   <= '0;
            r_buf[0] <= HEADER;
            for (int i = 0; i < 8; i++)
              r_buf[i+1] <= i_send_data[(7-i)*8 +: 8];
            r_buf[9] <= w_csum;
          end
        end
        S_START: begin
          if (w_baud_end) begin
            r_baud  <= '0;
            r_bit   <= '0;
            r_state <= S_DATA;
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        S_DATA: begin
          if (w_baud_end) begin
            r_baud <= '0;
            if (r_bit == 3'd7) begin
              r_bit   <= '0;
              r_state <= S_STOP;
            end else begin
              r_bit <= r_bit + 1'b1;
            end
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        S_STOP: begin
          if (w_baud_end) begin
            r_baud <= '0;
            if (r_byte < 4'd9) begin
              r_byte  <= r_byte + 1'b1;
              r_state <= S_START;
            end else begin
              r_byte  <= '0;
              r_state <= S_IDLE;
            end
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_uart_txd  = r_txd;
  assign o_tx_busy   = r_busy;
  assign o_send_done = r_done;

endmodule
